// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALU
// operation/operand-select codes and the sequencer state encoding.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUSRCB_RT      = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

   localparam logic [3:0] ST_FETCH_ENC    = 4'd0;
   localparam logic [3:0] ST_DECODE_ENC   = 4'd1;
   localparam logic [3:0] ST_MEM_ADDR_ENC = 4'd2;
   localparam logic [3:0] ST_MEM_RD_ENC   = 4'd3;
   localparam logic [3:0] ST_MEM_WR_ENC   = 4'd4;
   localparam logic [3:0] ST_LW_WB_ENC    = 4'd5;
   localparam logic [3:0] ST_R_EXEC_ENC   = 4'd6;
   localparam logic [3:0] ST_R_WB_ENC     = 4'd7;
   localparam logic [3:0] ST_BEQ_ENC      = 4'd8;
   localparam logic [3:0] ST_ERROR_ENC    = 4'd9;

   typedef enum logic [3:0] {
      S_FETCH    = ST_FETCH_ENC,
      S_DECODE   = ST_DECODE_ENC,
      S_MEM_ADDR = ST_MEM_ADDR_ENC,
      S_MEM_RD   = ST_MEM_RD_ENC,
      S_MEM_WR   = ST_MEM_WR_ENC,
      S_LW_WB    = ST_LW_WB_ENC,
      S_R_EXEC   = ST_R_EXEC_ENC,
      S_R_WB     = ST_R_WB_ENC,
      S_BEQ      = ST_BEQ_ENC,
      S_ERROR    = ST_ERROR_ENC
   } state_e;

   // States that talk to memory and may therefore stall on mem_ready.
   function automatic logic is_mem_state(state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the R-type/LW/SW/BEQ MIPS subset over a
// single shared instruction/data memory with mem_ready stalls.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instr at PC, PC+4 into PC when memory completes
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | base + sign-ext offset into ALUOut
// MEM_RD   | load data read at ALUOut
// MEM_WR   | store rt at ALUOut (final state of SW)
// LW_WB    | MDR into rt (final state of LW)
// R_EXEC   | rs op rt, funct-decoded
// R_WB     | ALUOut into rd (final state of R-type)
// BEQ      | rs - rt, PC <- branch target if zero (final state of BEQ)
// ERROR    | illegal opcode or memory timeout, parked until rst
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             pc_source,
   output logic             illegal_instr,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              illegal_q, illegal_d;
   logic              timeout_q, timeout_d;
   logic              retire;
   logic              stall_expired;

   // zero only qualifies pc_write_cond inside the datapath; the sequence
   // itself is identical for taken and not-taken branches.
   logic zero_unused;
   assign zero_unused = zero;

   // Next state, sticky flags and retire strobe.
   always_comb begin
      state_d       = state_q;
      illegal_d     = illegal_q;
      timeout_d     = timeout_q;
      retire        = 1'b0;
      stall_expired = is_mem_state(state_q) && !mem_ready
                      && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
      unique case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               default: begin
                  state_d   = S_ERROR;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_d = S_LW_WB;
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_LW_WB, S_R_WB, S_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_R_EXEC:   state_d = S_R_WB;
         S_ERROR:    state_d = S_ERROR;
         default:    state_d = S_ERROR;
      endcase
      if (stall_expired) begin
         state_d   = S_ERROR;
         timeout_d = 1'b1;
      end
   end

   // Stall counter restarts on every state change and whenever memory answers.
   always_comb begin
      wait_d = '0;
      if (is_mem_state(state_q) && !mem_ready && (state_d == state_q))
         wait_d = wait_q + WAIT_W'(1);
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   // State, counters and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         retired_q <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // Moore control decode; everything held low while rst is asserted.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALUSRCB_RT;
      alu_op        = ALUOP_ADD;
      pc_source     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = ALUSRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = ALUSRCB_IMM_SH2;
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = ALUSRCB_IMM;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            S_LW_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BEQ: begin
               alu_src_a     = 1'b1;
               alu_op        = ALUOP_SUB;
               pc_write_cond = 1'b1;
               pc_source     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign illegal_instr = illegal_q;
   assign mem_timeout   = timeout_q;
   assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios with literal
// expectations, then randomized instruction/stall/reset traffic, all checked
// every cycle against an instruction-level step-queue model.
module tb_multicycle_control_fsm;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 5;

   localparam int ST_F = 0, ST_D = 1, ST_A = 2, ST_RD = 3, ST_WR = 4;
   localparam int ST_LWB = 5, ST_RX = 6, ST_RWB = 7, ST_BQ = 8, ST_ERR = 9;

   logic clk, rst, zero, mem_ready;
   logic [5:0] opcode;
   logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic reg_write, reg_dst, mem_to_reg, alu_src_a, pc_source;
   logic [1:0] alu_src_b, alu_op;
   logic illegal_instr, mem_timeout;
   logic [CNT_W-1:0] retired;

   multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_instr(illegal_instr),
      .mem_timeout(mem_timeout), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   // Reference model: current step plus the steps the decoded instruction still owes.
   int               m_step = ST_F;
   int               m_rest[$];
   int               m_wait = 0;
   bit               m_ill = 0, m_to = 0;
   logic [CNT_W-1:0] m_ret = '0;

   logic [14:0] dut_ctrl;
   assign dut_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                      pc_source};

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic r);
      logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
      logic rw = 0, rd = 0, m2r = 0, sa = 0, pcs = 0;
      logic [1:0] sb = 2'b00, op = 2'b00;
      if (!r) begin
         case (st)
            ST_F:   begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            ST_D:   sb = 2'b11;
            ST_A:   begin sa = 1; sb = 2'b10; end
            ST_RD:  begin mrd = 1; io = 1; end
            ST_WR:  begin mwr = 1; io = 1; end
            ST_LWB: begin rw = 1; m2r = 1; end
            ST_RX:  begin sa = 1; op = 2'b10; end
            ST_RWB: begin rw = 1; rd = 1; end
            ST_BQ:  begin sa = 1; op = 2'b01; pwc = 1; pcs = 1; end
            default: ;
         endcase
      end
      return {pw, pwc, io, mrd, mwr, irw, rw, rd, m2r, sa, sb, op, pcs};
   endfunction

   function automatic bit is_mem(input int st);
      return (st == ST_F) || (st == ST_RD) || (st == ST_WR);
   endfunction

   // Move to the next owed step, or retire and refetch when none remain.
   task automatic m_next();
      m_wait = 0;
      if (m_rest.size() == 0) begin
         m_ret  = m_ret + 1'b1;
         m_step = ST_F;
      end else begin
         m_step = m_rest.pop_front();
      end
   endtask

   // Compare every cycle, then advance the model with the inputs the DUT is about to sample.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ctrl", int'(dut_ctrl), int'(exp_ctrl(m_step, mem_ready, rst)));
         chk("illegal_instr", int'(illegal_instr), int'(m_ill));
         chk("mem_timeout", int'(mem_timeout), int'(m_to));
         chk("retired", int'(retired), int'(m_ret));
         chk("rd_wr_exclusive", int'(mem_read & mem_write), 0);
      end
      if (rst) begin
         m_step = ST_F; m_rest.delete(); m_wait = 0;
         m_ill = 0; m_to = 0; m_ret = '0;
      end else if (is_mem(m_step)) begin
         if (mem_ready) begin
            if (m_step == ST_F) begin m_step = ST_D; m_wait = 0; end
            else m_next();
         end else if (m_wait + 1 >= MEM_TIMEOUT) begin
            m_step = ST_ERR; m_to = 1;
         end else begin
            m_wait++;
         end
      end else if (m_step == ST_D) begin
         case (opcode)
            6'h00: m_rest = '{ST_RX, ST_RWB};
            6'h23: m_rest = '{ST_A, ST_RD, ST_LWB};
            6'h2B: m_rest = '{ST_A, ST_WR};
            6'h04: m_rest = '{ST_BQ};
            default: m_rest.delete();
         endcase
         if (m_rest.size() == 0) begin m_step = ST_ERR; m_ill = 1; end
         else m_next();
      end else if (m_step != ST_ERR) begin
         m_next();
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) adv();
      rst = 1'b0;
   endtask

   initial begin
      int burst;
      int err_cycles;
      int r;
      rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      chk_en = 1;

      // R-type, zero-wait memory: writeback in cycle 4.
      opcode = 6'h00; mem_ready = 1'b1;
      do_reset(2);
      at_neg();
      chk("reset_retired", int'(retired), 0);
      chk("reset_flags", int'({illegal_instr, mem_timeout}), 0);
      chk("fetch_mem_read", int'(mem_read), 1);
      chk("fetch_ir_write", int'(ir_write), 1);
      repeat (3) adv();
      at_neg();
      chk("rtype_c4_regwrite_dst", int'({reg_write, reg_dst, mem_to_reg}), 3'b110);
      adv(); at_neg();
      chk("rtype_retired", int'(retired), 1);

      // LW with two stall cycles in MEM_RD: LW_WB in cycle 7.
      opcode = 6'h23; mem_ready = 1'b1;
      do_reset(2);
      adv(); adv();
      at_neg();
      chk("lw_c3_memaddr", int'({alu_src_a, alu_src_b}), 3'b110);
      adv(); mem_ready = 1'b0;
      at_neg();
      chk("lw_c4_stall_read", int'({mem_read, iord, mem_write}), 3'b110);
      adv(); adv(); mem_ready = 1'b1;
      adv();
      at_neg();
      chk("lw_c7_writeback", int'({reg_write, reg_dst, mem_to_reg}), 3'b101);
      chk("lw_no_timeout", int'(mem_timeout), 0);
      adv(); at_neg();
      chk("lw_retired", int'(retired), 1);

      // SW then BEQ (zero=1).
      opcode = 6'h2B; mem_ready = 1'b1; zero = 1'b1;
      do_reset(2);
      adv(); adv();
      at_neg();
      chk("sw_c3_no_write", int'(mem_write), 0);
      adv();
      at_neg();
      chk("sw_c4_write", int'({mem_write, mem_read, iord}), 3'b101);
      adv(); opcode = 6'h04;
      adv(); adv();
      at_neg();
      chk("beq_c7_cond_src", int'({pc_write_cond, pc_source, alu_op}), 4'b1101);
      adv(); at_neg();
      chk("sw_beq_retired", int'(retired), 2);

      // Illegal opcode: parked in ERROR with every control low.
      opcode = 6'h3F; mem_ready = 1'b1; zero = 1'b0;
      do_reset(2);
      adv(); adv();
      at_neg();
      chk("illegal_flag", int'(illegal_instr), 1);
      for (int i = 0; i < 20; i++) begin
         at_neg();
         chk("illegal_ctrl_zero", int'(dut_ctrl), 0);
         adv();
      end
      opcode = 6'h00;
      do_reset(1);
      at_neg();
      chk("illegal_cleared", int'(illegal_instr), 0);
      chk("illegal_back_fetch", int'(mem_read), 1);

      // Memory never answers in FETCH: ERROR after 16 stall cycles.
      mem_ready = 1'b0;
      do_reset(2);
      repeat (15) adv();
      at_neg();
      chk("timeout_c16_still_fetch", int'({mem_read, mem_timeout}), 2'b10);
      adv();
      at_neg();
      chk("timeout_c17_flag", int'({mem_read, mem_timeout}), 2'b01);
      chk("timeout_retired", int'(retired), 0);

      // Reset during MEM_WR aborts the store.
      opcode = 6'h2B; mem_ready = 1'b1;
      do_reset(2);
      repeat (3) adv();
      rst = 1'b1;
      at_neg();
      chk("rst_in_memwr_write_low", int'(mem_write), 0);
      adv(); rst = 1'b0;
      at_neg();
      chk("rst_in_memwr_fetch", int'({mem_read, mem_write}), 2'b10);
      chk("rst_in_memwr_retired", int'(retired), 0);

      // Randomized traffic.
      do_reset(2);
      burst = 0; err_cycles = 0;
      for (int c = 0; c < 4000; c++) begin
         if (m_step == ST_F) begin
            r = $urandom_range(19);
            if (r < 5)       opcode = 6'h00;
            else if (r < 10) opcode = 6'h23;
            else if (r < 15) opcode = 6'h2B;
            else if (r < 19) opcode = 6'h04;
            else             opcode = 6'($urandom);
         end
         if (burst > 0) begin
            mem_ready = 1'b0; burst--;
         end else begin
            r = $urandom_range(99);
            mem_ready = (r < 70);
            if (r >= 97) burst = $urandom_range(20, 10);
         end
         err_cycles = (m_step == ST_ERR) ? err_cycles + 1 : 0;
         rst  = (err_cycles > 3) || ($urandom_range(999) < 4);
         zero = 1'($urandom);
         adv();
      end
      rst = 1'b0;
      at_neg();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
